// File: rtl/ttfir_mac.sv
// ttfir_mac: time-multiplexed FIR core that evaluates one tap per cycle through
// a single multiplier-accumulator. Coefficients and samples share one
// valid/ready input port, qualified by mode.
// Optional feature macro: TTFIR_SAT_EN. When it is defined, the output saturates
// and sat_flag is sticky. When it is undefined, the output wraps and sat_flag is 0.
module ttfir_mac #(
    parameter int N_TAPS  = 6,
    parameter int BW_IN   = 6,
    parameter int BW_COEF = 6,
    parameter int BW_ACC  = 15,
    parameter int BW_OUT  = 8,
    parameter int SHIFT   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BW_IN-1:0]  in_data,
    output logic              out_valid,
    output logic [BW_OUT-1:0] out_data,
    output logic              coef_ok,
    output logic              sat_flag
);
    localparam int BW_PROD = BW_IN + BW_COEF;
    localparam int IDX_W   = $clog2(N_TAPS);
    localparam int CNT_W   = $clog2(N_TAPS + 1);

    typedef enum logic {IDLE, MAC} state_e;

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic signed [BW_ACC-1:0]  acc_q, acc_d;
    logic signed [BW_COEF-1:0] c_q [N_TAPS];
    logic signed [BW_COEF-1:0] c_d [N_TAPS];
    logic signed [BW_IN-1:0]   x_q [N_TAPS];
    logic signed [BW_IN-1:0]   x_d [N_TAPS];
    logic [BW_OUT-1:0]         out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;

    logic                      accept;
    logic                      last_tap;
    logic signed [BW_PROD-1:0] prod;
    logic signed [BW_ACC-1:0]  sum;
    logic [BW_OUT-1:0]         result;

    // State register of the IDLE/MAC sequencer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; combinational
        // blocks use blocking ones so later statements see earlier results.
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a loaded sample starts a MAC run, the last tap ends it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !mode && coef_ok) state_d = MAC;
            MAC:  if (last_tap) state_d = IDLE;
        endcase
    end

    // Output decode: handshake, load status and registered result.
    always_comb begin
        in_ready  = (state_q == IDLE) && !reset;
        accept    = in_valid && in_ready;
        last_tap  = (idx_q == IDX_W'(N_TAPS - 1));
        coef_ok   = (count_q == CNT_W'(N_TAPS));
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

    // One tap product, sign-extended into the wrapping accumulator.
    always_comb begin
        prod = BW_PROD'(x_q[idx_q]) * BW_PROD'(c_q[idx_q]);
        sum  = acc_q + BW_ACC'(prod);
    end

`ifdef TTFIR_SAT_EN
    localparam logic signed [BW_ACC-1:0] SAT_MAX = BW_ACC'((2 ** (BW_OUT - 1)) - 1);
    localparam logic signed [BW_ACC-1:0] SAT_MIN = ~SAT_MAX;

    logic signed [BW_ACC-1:0] shifted;
    logic                     result_sat;
    logic                     sat_q, sat_d;

    // Output format: scale, then clamp to the signed output range.
    always_comb begin
        shifted    = sum >>> SHIFT;
        result     = shifted[BW_OUT-1:0];
        result_sat = 1'b0;
        if (shifted > SAT_MAX) begin
            result     = SAT_MAX[BW_OUT-1:0];
            result_sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            result     = SAT_MIN[BW_OUT-1:0];
            result_sat = 1'b1;
        end
        sat_d = sat_q | (state_q == MAC && last_tap && result_sat);
    end

    // Sticky saturation flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) sat_q <= 1'b0;
        else       sat_q <= sat_d;
    end

    assign sat_flag = sat_q;
`else
    // Output format: scale, then keep the low output bits (wrap).
    always_comb begin
        result = BW_OUT'(sum >>> SHIFT);
    end

    assign sat_flag = 1'b0;
`endif

    // Datapath next values: coefficient/sample shifts and MAC steps.
    always_comb begin
        count_d     = count_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        c_d         = c_q;
        x_d         = x_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        if (accept && mode) begin
            for (int k = N_TAPS - 1; k > 0; k--) c_d[k] = c_q[k-1];
            c_d[0] = in_data[BW_COEF-1:0];
            if (coef_ok) begin
                // A write after a complete set starts a fresh set and flushes
                // history filtered with the old coefficients.
                count_d = CNT_W'(1);
                for (int k = 0; k < N_TAPS; k++) x_d[k] = '0;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (accept && coef_ok) begin
            for (int k = N_TAPS - 1; k > 0; k--) x_d[k] = x_q[k-1];
            x_d[0] = in_data;
            acc_d  = '0;
            idx_d  = '0;
        end else if (state_q == MAC) begin
            if (last_tap) begin
                out_data_d  = result;
                out_valid_d = 1'b1;
            end else begin
                acc_d = sum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the coefficient and delay arrays are reset explicitly;
            // reset must leave an empty filter with no stale history.
            for (int k = 0; k < N_TAPS; k++) begin
                c_q[k] <= '0;
                x_q[k] <= '0;
            end
            count_q     <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            c_q         <= c_d;
            x_q         <= x_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: doc/ttfir_mac.md
# ttfir_mac

Parametrised, time-multiplexed FIR filter core. It is the successor to the fixed 6-tap parallel FIR. Coefficients and samples arrive over one valid/ready input port, and a single multiplier-accumulator evaluates one tap per cycle. It adds configurable depth and widths, output scaling, coefficient reload and optional saturation. A pin wrapper maps the ports onto the 8-bit tile I/O.

## Interface
- N_TAPS, 6: number of taps, 2..16.
- BW_IN, 6: sample width, signed.
- BW_COEF, 6: coefficient width, signed; coefficients arrive on the low BW_COEF bits of in_data (BW_COEF ≤ BW_IN).
- BW_ACC, 15: accumulator width, signed; must be ≥ BW_IN+BW_COEF+clog2(N_TAPS).
- BW_OUT, 8: output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before output.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- mode  in  1  0 = sample, 1 = coefficient; qualifies in_data.
- in_valid  in  1  input word offered.
- in_ready  out  1  high only in IDLE and not in reset.
- in_data  in  BW_IN  sample or coefficient.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  BW_OUT  last result, held until the next result.
- coef_ok  out  1  all N_TAPS coefficients of the current set loaded.
- sat_flag  out  1  sticky saturation indicator (see Configuration).

## Operation
- Accept: occurs on a rising edge with in_valid && in_ready.
- Coefficient accept (mode=1):
  - c[0] <= in_data[BW_COEF-1:0]; c[k] <= c[k-1].
  - The load counter increments. coef_ok = (count == N_TAPS).
  - If coef_ok was already 1, a new set starts: count <= 1, coef_ok drops, and every x[k] is cleared to 0.
  - The first-written coefficient of a set ends in c[N_TAPS-1].
- Sample accept (mode=0) with coef_ok=0:
  - The word is consumed and discarded.
  - No delay-line change, no out_valid.
- Sample accept (mode=0) with coef_ok=1:
  - x[0] <= in_data; x[k] <= x[k-1] (x[0] is newest).
  - acc <= 0, idx <= 0, state → MAC.
- State machine: IDLE → MAC → IDLE.
  - MAC, idx < N_TAPS-1: acc <= acc + x[idx]*c[idx]; idx++.
  - MAC, idx = N_TAPS-1: out_data <= fmt(acc + x[idx]*c[idx]); out_valid <= 1; state → IDLE.
- Arithmetic:
  - Products are full-width signed (BW_IN+BW_COEF bits).
  - The accumulator is sign-extended to BW_ACC and wraps modulo 2^BW_ACC.
  - fmt(v) = (v >>> SHIFT) reduced to BW_OUT bits per Configuration.
- Result: y[n] = Σ c[k]·x[n-k].
- Reset: state IDLE; all c, x, acc, idx, count = 0; out_data=0, out_valid=0, coef_ok=0, sat_flag=0, in_ready=0 while reset is high.
- Reset mid-MAC: the computation is aborted, no out_valid is produced and the coefficients are lost.
- mode and in_data are ignored whenever in_ready=0.

## Timing
- Sample accepted at edge e0: MAC steps run at edges e1..eN (N = N_TAPS). out_valid is high for the one cycle following eN.
- in_ready is low from after e0 until after eN, and high again in the same cycle out_valid is high. Earliest next accept is edge eN+1.
- Sample throughput: one per N_TAPS+1 cycles.
- Coefficient and discarded-sample accepts take one cycle. in_ready stays high.
- out_valid never asserts for two consecutive cycles.

## Configuration
- TTFIR_SAT_EN defined:
  - fmt clamps the shifted value to [-2^(BW_OUT-1), 2^(BW_OUT-1)-1].
  - Any clamped result sets sat_flag, which is cleared only by reset.
- TTFIR_SAT_EN undefined:
  - fmt takes the low BW_OUT bits (wrap).
  - sat_flag is tied to 0.

## Test plan
All cases use default parameters.
- Impulse response:
  - Stimulus: reset, then coefficients 1,2,3,4,5,6 (coef_ok rises after the 6th), then samples 1,0,0,0,0,0,0.
  - Required: out_data 6,5,4,3,2,1,0.
- Latency and handshake:
  - Stimulus: hold in_valid high with samples.
  - Required: in_ready low for exactly 6 cycles after each accept; out_valid pulses 6 edges after each accept; accepts are 7 cycles apart.
- Not-loaded discard:
  - Stimulus: after 3 coefficients, send sample 7, then finish loading and send sample 0.
  - Required: no out_valid for the 7; the later result is 0.
- Overflow:
  - Stimulus 1: all coefficients 31, six samples of 31.
  - Required: 6th result 0x86 without the macro; 0x7F with sat_flag=1 with TTFIR_SAT_EN.
  - Stimulus 2: all coefficients 31, samples of -32.
  - Required: 0xC0 (wrap) / 0x80 (sat).
- Reload:
  - Stimulus: after a run, write one coefficient 2.
  - Required: coef_ok falls, delay line cleared; after 5 more coefficients of 0, impulse 1 gives outputs 0,0,0,0,0,2.
- Reset mid-MAC:
  - Stimulus: assert reset 3 cycles after a sample accept.
  - Required: no out_valid; out_data=0, coef_ok=0, in_ready=1 the cycle after reset deasserts.
